// File: rtl/serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// serial_alu_ctrl
//
// Purpose:
//   Controls one external 1-bit ALU slice (alu1). It performs a WIDTH-bit
//   operation bit-serially, starting with the LSB. The carry out of each
//   slice cycle feeds the carry in of the next cycle for every op code. The
//   block never decodes op; it only forwards it to the slice.
//
//   FSM: IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
//   - A start seen in IDLE latches a, b, op and cin.
//   - The op then occupies WIDTH RUN cycles.
//   - Result and carry become valid in the DONE cycle, which also pulses done.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             operation request, sampled only in IDLE
//   i_a, i_b            WIDTH-bit operands (captured on accept)
//   i_op                3-bit slice select (captured on accept)
//   i_cin               carry into bit 0 (captured on accept)
//   o_busy              high in RUN cycles only
//   o_done              one-cycle pulse in DONE
//   o_result            result of last completed op (held)
//   o_carry_flag        final slice carry of last completed op (held)
//   o_slice_a/b/cin     bit operands and carry to the slice
//   o_slice_select      op code to the slice (latched op)
//   i_slice_out/cout    slice sum/logic output and carry output
//   o_dbg_state         current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake:
//   start/busy/done form a simple request/pulse protocol.
//   - A request is accepted only in a cycle where the FSM is IDLE and
//     start=1; that cycle is T.
//   - busy is high for T+1..T+WIDTH.
//   - done pulses at T+WIDTH+1. result and carry_flag are valid from then
//     until the next completion or reset.
//   - start is ignored whenever the FSM is not IDLE.
// ---------------------------------------------------------------------------
module serial_alu_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_flag,
  output logic             o_slice_a,
  output logic             o_slice_b,
  output logic             o_slice_cin,
  output logic [2:0]       o_slice_select,
  input  logic             i_slice_out,
  input  logic             i_slice_cout,
  output logic [1:0]       o_dbg_state
);

  // One spare bit, so the counter can never wrap within an op.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;       // shifted right each RUN cycle; bit 0 = current bit
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_cin;
  logic             r_carry;   // slice carry captured in the previous RUN cycle
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_work;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_flag;

  logic             w_run;
  logic [WIDTH-1:0] w_bit_mask;
  logic [WIDTH-1:0] w_work_next;

  assign w_run       = (r_state == S_RUN);
  // Put the slice output into working bit k (k = r_cnt).
  assign w_bit_mask  = WIDTH'(1) << r_cnt;
  assign w_work_next = i_slice_out ? (r_work | w_bit_mask) : r_work;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_cin        <= 1'b0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      r_work       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_carry_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_op    <= i_op;
            r_cin   <= i_cin;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_work  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= i_slice_cout;
          r_work  <= w_work_next;
          if (r_cnt == LAST_BIT) begin
            r_result     <= w_work_next;
            r_carry_flag <= i_slice_cout;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Slice drive: operands and carry only in RUN, select always shows latched op.
  assign o_slice_a      = w_run & r_a[0];
  assign o_slice_b      = w_run & r_b[0];
  assign o_slice_cin    = w_run & ((r_cnt == '0) ? r_cin : r_carry);
  assign o_slice_select = r_op;

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_result       = r_result;
  assign o_carry_flag   = r_carry_flag;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_alu_ctrl
//
// Self-checking bench for serial_alu_ctrl with WIDTH=4.
//
// The alu1 slice is modelled behaviourally:
//   - op 011: ADD
//   - op 111: AND
//   - any other op: OR
//   - carry_out is the full-adder carry for every op.
//
// The reference model works on whole words:
//   - {carry, result} = a + b + cin for ADD.
//   - For AND, result = a & b, and carry is the top bit of a + b + cin.
// ---------------------------------------------------------------------------
module tb_serial_alu_ctrl;
  localparam int W = 4;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_AND = 3'b111;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_flag;
  logic         s_a;
  logic         s_b;
  logic         s_cin;
  logic [2:0]   s_sel;
  logic         s_out;
  logic         s_cout;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_a(a), .i_b(b), .i_op(op), .i_cin(cin),
    .o_busy(busy), .o_done(done), .o_result(result), .o_carry_flag(carry_flag),
    .o_slice_a(s_a), .o_slice_b(s_b), .o_slice_cin(s_cin), .o_slice_select(s_sel),
    .i_slice_out(s_out), .i_slice_cout(s_cout), .o_dbg_state(dbg_state)
  );

  // Behavioural alu1 slice
  always_comb begin
    s_cout = (s_a & s_b) | (s_a & s_cin) | (s_b & s_cin);
    case (s_sel)
      3'b011:  s_out = s_a ^ s_b ^ s_cin;
      3'b111:  s_out = s_a & s_b;
      default: s_out = s_a | s_b;
    endcase
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_alu(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                         input logic [2:0] rop, input logic rcin);
    logic [W:0] sum;
    sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
    if (rop == OP_AND) return {sum[W], ra & rb};
    return sum;
  endfunction

  // Driver: issue one op from IDLE and observe W+4 cycles after acceptance.
  // Operands are scrambled after acceptance to show they are not re-sampled.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] top,
                        input logic tcin, output logic [W-1:0] res, output logic cf,
                        output int lat, output int busy_mask, output int done_n,
                        output logic sel_ok, output logic [W-1:0] res_hold);
    a = ta; b = tb_; op = top; cin = tcin; start = 1'b1;
    res = '0; cf = 1'b0; lat = -1; busy_mask = 0; done_n = 0; sel_ok = 1'b1;
    for (int c = 1; c <= W + 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15));
      op = 3'($urandom_range(0, 7)); cin = 1'($urandom_range(0, 1));
      if (busy) begin
        busy_mask = busy_mask | (1 << c);
        if (s_sel !== top) sel_ok = 1'b0;
      end
      if (done) begin
        done_n++;
        if (lat < 0) begin lat = c; res = result; cf = carry_flag; end
      end
    end
    res_hold = result;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, carry_flag, dbg_state, s_a, s_b, s_cin, s_sel} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%b cf=%b st=%0d sa=%b sb=%b scin=%b sel=%b expected all zero",
               busy, done, result, carry_flag, dbg_state, s_a, s_b, s_cin, s_sel);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    logic [W-1:0] res, hold; logic cf, sel_ok; int lat, bm, dn;
    run_op(4'b0111, 4'b0001, OP_ADD, 1'b0, res, cf, lat, bm, dn, sel_ok, hold);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d expected 5", lat); end
    checks++;
    if (bm !== 32'b11110) begin errors++; $display("FAIL add_busy_cycles: mask %b expected 11110", bm); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL add_done_width: got %0d expected 1", dn); end
    checks++;
    if ({cf, res} !== 5'b0_1000) begin errors++; $display("FAIL add_0111_0001: got cf=%b res=%b expected cf=0 res=1000", cf, res); end
    checks++;
    if (hold !== 4'b1000) begin errors++; $display("FAIL add_result_hold: got %b expected 1000", hold); end
  endtask

  task automatic test_add_boundary();
    logic [W-1:0] res, hold; logic cf, sel_ok; int lat, bm, dn;
    run_op(4'b1111, 4'b0001, OP_ADD, 1'b0, res, cf, lat, bm, dn, sel_ok, hold);
    checks++;
    if ({cf, res} !== 5'b1_0000) begin errors++; $display("FAIL add_overflow: got cf=%b res=%b expected cf=1 res=0000", cf, res); end
    run_op(4'b0000, 4'b0000, OP_ADD, 1'b1, res, cf, lat, bm, dn, sel_ok, hold);
    checks++;
    if ({cf, res} !== 5'b0_0001) begin errors++; $display("FAIL add_cin_only: got cf=%b res=%b expected cf=0 res=0001", cf, res); end
  endtask

  task automatic test_and();
    logic [W-1:0] res, hold; logic cf, sel_ok; int lat, bm, dn;
    run_op(4'b1100, 4'b1010, OP_AND, 1'b0, res, cf, lat, bm, dn, sel_ok, hold);
    checks++;
    if (res !== 4'b1000) begin errors++; $display("FAIL and_result: got %b expected 1000", res); end
    checks++;
    if (sel_ok !== 1'b1) begin errors++; $display("FAIL and_select: select not 111 in some RUN cycle, got ok=%b expected 1", sel_ok); end
    // Idle slice drive: zero operands/carry, select keeps the latched op.
    checks++;
    if ({s_a, s_b, s_cin, s_sel} !== {3'b000, OP_AND}) begin
      errors++; $display("FAIL idle_slice_drive: got a=%b b=%b cin=%b sel=%b expected 0 0 0 111", s_a, s_b, s_cin, s_sel);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ha[0:15]; logic [W-1:0] hb[0:15]; logic [2:0] hop[0:15]; logic hcin[0:15];
    int done_at[$]; logic [W:0] got[$]; logic [W:0] e0, e1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (done) begin done_at.push_back(c); got.push_back({carry_flag, result}); end
      end
      start = 1'b1;
      ha[c] = W'($urandom_range(0, 15)); hb[c] = W'($urandom_range(0, 15));
      hop[c] = $urandom_range(0, 1) ? OP_ADD : OP_AND; hcin[c] = 1'($urandom_range(0, 1));
      a = ha[c]; b = hb[c]; op = hop[c]; cin = hcin[c];
    end
    start = 1'b0;
    e0 = ref_alu(ha[0], hb[0], hop[0], hcin[0]);
    e1 = ref_alu(ha[6], hb[6], hop[6], hcin[6]);
    checks++;
    if (done_at.size() != 2 || done_at[0] != 5 || done_at[1] != 11) begin
      errors++;
      $display("FAIL b2b_done_cycles: got %0d pulses first=%0d second=%0d expected 5 and 11",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -1, (done_at.size() > 1) ? done_at[1] : -1);
    end else begin
      checks++;
      if (got[0] !== e0) begin errors++; $display("FAIL b2b_first_result: got %b expected %b", got[0], e0); end
      checks++;
      if (got[1] !== e1) begin errors++; $display("FAIL b2b_second_result: got %b expected %b", got[1], e1); end
    end
    // Drain the op accepted at cycle 12.
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int stray;
    a = 4'b1111; b = 4'b1111; op = OP_ADD; cin = 1'b1; start = 1'b1;   // cycle T
    @(posedge clk); #1; start = 1'b0;                                  // T+1
    @(posedge clk); #1; reset = 1'b1;                                  // T+2
    @(posedge clk); #1;                                                // T+3
    checks++;
    if ({busy, done, result, carry_flag, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b result=%b cf=%b st=%0d expected all zero",
               busy, done, result, carry_flag, dbg_state);
    end
    reset = 1'b0;
    stray = 0;
    repeat (10) begin @(posedge clk); #1; if (done || busy) stray++; end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL reset_no_done: %0d busy/done cycles after abort expected 0", stray); end
    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_priority: busy=%b st=%0d expected 0 0", busy, dbg_state);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] res, hold, ra, rb; logic cf, sel_ok, rcin; logic [2:0] rop;
    int lat, bm, dn; logic [W:0] exp;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 15)); rb = W'($urandom_range(0, 15));
      rop = $urandom_range(0, 1) ? OP_ADD : OP_AND; rcin = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_alu(ra, rb, rop, rcin));
      run_op(ra, rb, rop, rcin, res, cf, lat, bm, dn, sel_ok, hold);
      exp = exp_q.pop_front();
      checks++;
      if ({cf, res} !== exp) begin
        errors++; $display("FAIL rand_result[%0d]: a=%b b=%b op=%b cin=%b got %b expected %b", n, ra, rb, rop, rcin, {cf, res}, exp);
      end
      checks++;
      if (dn !== 1 || lat !== 5) begin
        errors++; $display("FAIL rand_done[%0d]: pulses=%0d at=%0d expected 1 at 5", n, dn, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_boundary();
    test_and();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit as a guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
